// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with a 3-sample majority vote per bit and a runtime frame format.
// A byte is reported one clk after the last stop bit's vote; parity/framing/break flags are reported with it.
module uart_rx_ovs #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        rx_enable_i,
    input  logic [31:0] clk_div_i,
    input  logic [3:0]  data_bits_i,
    input  logic [1:0]  parity_mode_i,
    input  logic        stop_bits_i,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_parity_err_o,
    output logic        rx_frame_err_o,
    output logic        rx_break_o,
    output logic        rx_busy_o
);
    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] SMP0 = OW'(OVS/2 - 1);
    localparam logic [OW-1:0] SMP1 = OW'(OVS/2);
    localparam logic [OW-1:0] SMP2 = OW'(OVS/2 + 1);
    localparam logic [OW-1:0] LAST = OW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_prev_q, fall;
    logic [31:0]            div_q, div_d;
    logic                   tick, mid, bnd, vote, par_en;

    state_t         state_q;
    logic [OW-1:0]  os_q;
    logic [3:0]     bit_cnt_q, nbits_q;
    logic [1:0]     pmode_q;
    logic           stop2_q, stop_cnt_q;
    logic           s0_q, s1_q;
    logic [7:0]     shreg_q, data_q;
    logic           xor_q, perr_q, ferr_q, lo_q;
    logic           valid_q, perr_o_q, ferr_o_q, brk_q, busy_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rxs_prev_q <= rxs;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_prev_q & ~rxs;

    // >= rather than == so a divider lowered at runtime never leaves the counter stranded above it
    assign tick = rx_enable_i && (div_q >= clk_div_i);

    always_comb begin
        div_d = div_q + 32'd1;
        if (!rx_enable_i || tick || (state_q == IDLE && fall))
            div_d = '0;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) div_q <= '0;
        else         div_q <= div_d;
    end

    assign mid    = tick && (os_q == SMP2);
    assign bnd    = tick && (os_q == LAST);
    assign vote   = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign par_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            os_q       <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= '0;
            pmode_q    <= '0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            shreg_q    <= '0;
            xor_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            lo_q       <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_o_q   <= 1'b0;
            ferr_o_q   <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
            if (!rx_enable_i) begin
                state_q    <= IDLE;
                os_q       <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                if (state_q != IDLE && tick) begin
                    os_q <= (os_q == LAST) ? '0 : os_q + OW'(1);
                    if (os_q == SMP0) s0_q <= rxs;
                    if (os_q == SMP1) s1_q <= rxs;
                end
                case (state_q)
                    IDLE: if (fall) begin
                        state_q    <= START;
                        busy_q     <= 1'b1;
                        os_q       <= '0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        nbits_q    <= (data_bits_i >= 4'd5 && data_bits_i <= 4'd8) ? data_bits_i : 4'd8;
                        pmode_q    <= parity_mode_i;
                        stop2_q    <= stop_bits_i;
                        shreg_q    <= '0;
                        xor_q      <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        lo_q       <= 1'b1;
                    end
                    START: begin
                        if (mid && vote) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (bnd) begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (mid) begin
                            shreg_q[bit_cnt_q[2:0]] <= vote;
                            xor_q     <= xor_q ^ vote;
                            lo_q      <= lo_q & ~vote;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        if (bnd && bit_cnt_q == nbits_q)
                            state_q <= par_en ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (mid) begin
                            perr_q <= (pmode_q == 2'b01) ? (xor_q ^ vote) : ~(xor_q ^ vote);
                            lo_q   <= lo_q & ~vote;
                        end
                        if (bnd) state_q <= STOP;
                    end
                    STOP: begin
                        // The last stop bit finishes the frame at its vote, leaving the rest of the bit for resync
                        if (mid && stop_cnt_q == stop2_q) begin
                            if (lo_q && !vote) begin
                                brk_q   <= 1'b1;
                                state_q <= BRK;
                            end else begin
                                valid_q  <= 1'b1;
                                data_q   <= shreg_q;
                                perr_o_q <= perr_q;
                                ferr_o_q <= ferr_q | ~vote;
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                            end
                        end else if (mid) begin
                            ferr_q <= ferr_q | ~vote;
                            lo_q   <= lo_q & ~vote;
                        end
                        if (bnd) stop_cnt_q <= 1'b1;
                    end
                    BRK: if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign rx_parity_err_o = perr_o_q;
    assign rx_frame_err_o  = ferr_o_q;
    assign rx_break_o      = brk_q;
    assign rx_busy_o       = busy_q;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: a frame-level model queues what each transmitted frame must produce,
// and a monitor checks every reported byte/break against it and that outputs hold in between.
module tb_uart_rx_ovs;
    localparam int OVS  = 16;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rstn_i, rx_enable_i, stop_bits_i, rx_i;
    logic [31:0] clk_div_i;
    logic [3:0]  data_bits_i;
    logic [1:0]  parity_mode_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_busy_o;

    uart_rx_ovs #(.OVS(OVS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rstn_i(rstn_i), .rx_enable_i(rx_enable_i), .clk_div_i(clk_div_i),
        .data_bits_i(data_bits_i), .parity_mode_i(parity_mode_i), .stop_bits_i(stop_bits_i),
        .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_parity_err_o(rx_parity_err_o), .rx_frame_err_o(rx_frame_err_o),
        .rx_break_o(rx_break_o), .rx_busy_o(rx_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       brk;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       expq[$];
    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, frame_t0 = 0, last_valid_cyc = 0;
    int         n_valid = 0, n_break = 0;
    logic [7:0] hold_d = '0, last_d = '0;
    logic       hold_pe = 0, hold_fe = 0, last_pe = 0, last_fe = 0, prev_v = 0, prev_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every reported event must be the oldest outstanding expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rstn_i) begin
            chk("reset_outputs", {rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o,
                                  rx_break_o, rx_busy_o}, 0);
            hold_d = '0; hold_pe = 0; hold_fe = 0; prev_v = 0; prev_b = 0;
        end else begin
            if (rx_valid_o) begin
                chk("valid_one_clk", prev_v, 0);
                chk("valid_and_break", rx_break_o, 0);
                if (expq.size() == 0 || expq[0].brk) begin
                    chk("spurious_valid", 1, 0);
                    hold_d = rx_data_o; hold_pe = rx_parity_err_o; hold_fe = rx_frame_err_o;
                end else begin
                    e = expq.pop_front();
                    chk("data", rx_data_o, e.d);
                    chk("parity_err", rx_parity_err_o, e.pe);
                    chk("frame_err", rx_frame_err_o, e.fe);
                    hold_d = e.d; hold_pe = e.pe; hold_fe = e.fe;
                end
                n_valid++;
                last_d = rx_data_o; last_pe = rx_parity_err_o; last_fe = rx_frame_err_o;
                last_valid_cyc = cyc;
            end else begin
                chk("outputs_hold", {rx_data_o, rx_parity_err_o, rx_frame_err_o},
                    {hold_d, hold_pe, hold_fe});
            end
            if (rx_break_o) begin
                chk("break_one_clk", prev_b, 0);
                if (expq.size() == 0 || !expq[0].brk) chk("spurious_break", 1, 0);
                else void'(expq.pop_front());
                n_break++;
            end
            prev_v = rx_valid_o; prev_b = rx_break_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_i = 1'b1;
        end
    endtask

    // gbit: data bit to glitch at its centre sample (<0 none); abort: 1 drop enable, 2 pulse reset, during data bit 4
    task automatic send(input logic [7:0] d, input int nb, input logic [1:0] pm, input logic s2,
                        input logic pflip, input logic [1:0] slow, input int gbit,
                        input int abort, input logic push);
        int         neb, tt;
        logic       pen, pb, v;
        logic       bits[$];
        logic [7:0] dm;
        exp_t       e;
        neb = (nb >= 5 && nb <= 8) ? nb : 8;
        dm  = '0;
        for (int i = 0; i < neb; i++) dm[i] = d[i];
        pen = (pm == 2'b01) || (pm == 2'b10);
        // Correct parity bit makes the count of ones even (even mode) or odd (odd mode)
        pb  = (^dm) ^ (pm == 2'b10) ^ pflip;
        bits.push_back(1'b0);
        for (int i = 0; i < neb; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pb);
        bits.push_back(~slow[0]);
        if (s2) bits.push_back(~slow[1]);
        e.d   = dm;
        e.pe  = pen && (pb != ((^dm) ^ (pm == 2'b10)));
        e.fe  = slow[0] | (s2 & slow[1]);
        e.brk = 1'b1;
        foreach (bits[i]) if (bits[i]) e.brk = 1'b0;
        if (push) expq.push_back(e);
        data_bits_i = nb[3:0]; parity_mode_i = pm; stop_bits_i = s2;
        tt = int'(clk_div_i) + 1;
        foreach (bits[b]) begin
            for (int i = 0; i < OVS * tt; i++) begin
                @(negedge clk);
                if (b == 0 && i == 0) frame_t0 = cyc;
                v = bits[b];
                if (gbit >= 0 && b == gbit + 1 && i >= 8 * tt + 1 && i < 9 * tt + 1) v = ~v;
                rx_i = v;
                if (abort != 0 && b == 5 && i == 2 * tt) begin
                    if (abort == 1) rx_enable_i = 1'b0;
                    else            rstn_i = 1'b0;
                end
                if (abort != 0 && b == 5 && i == 2 * tt + 3) begin
                    rx_enable_i = 1'b1;
                    rstn_i      = 1'b1;
                end
            end
        end
    endtask

    task automatic settle(input int nbits);
        idle(nbits * OVS * (int'(clk_div_i) + 1) + 4);
        chk("all_expected_reported", expq.size(), 0);
        expq.delete();
    endtask

    task automatic check_frame(input string name, input int nv0, input logic [7:0] d,
                               input logic pe, input logic fe);
        chk({name, "_count"}, n_valid - nv0, 1);
        chk({name, "_data"}, last_d, d);
        chk({name, "_perr"}, last_pe, pe);
        chk({name, "_ferr"}, last_fe, fe);
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nb0, lat, nom, saw, fell, bound;
        rstn_i = 0; rx_enable_i = 1; rx_i = 1; clk_div_i = 4;
        data_bits_i = 8; parity_mode_i = 0; stop_bits_i = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o,
                            rx_break_o, rx_busy_o}, 0);
        rstn_i = 1;
        idle(20);

        // 8N1 0xA5; the vote ends OVS/2+2 ticks into the stop bit, 9 bit times after the start edge
        nv = n_valid;
        send(8'hA5, 8, 2'b00, 0, 0, 2'b00, -1, 0, 1);
        settle(1);
        check_frame("a5", nv, 8'hA5, 0, 0);
        lat = last_valid_cyc - frame_t0;
        nom = 9 * OVS * 5 + (OVS / 2 + 2) * 5;
        chk("a5_latency", (lat >= nom - (SYNC + 2) && lat <= nom + (SYNC + 2)) ? nom : lat, nom);

        nv = n_valid; send(8'h35, 7, 2'b01, 0, 1, 2'b00, -1, 0, 1); settle(1);
        check_frame("7e1_bad", nv, 8'h35, 1, 0);
        nv = n_valid; send(8'h35, 7, 2'b01, 0, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("7e1_good", nv, 8'h35, 0, 0);
        nv = n_valid; send(8'h1F, 5, 2'b10, 1, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("5o2", nv, 8'h1F, 0, 0);

        nv = n_valid; send(8'h3C, 8, 2'b00, 1, 0, 2'b10, -1, 0, 1); settle(2);
        check_frame("8n2_ferr", nv, 8'h3C, 0, 1);
        nv = n_valid; send(8'h00, 8, 2'b00, 1, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("8n2_clean", nv, 8'h00, 0, 0);

        // 3-tick low glitch on an idle line
        nv = n_valid; nb0 = n_break; saw = 0; fell = -1;
        bound = (OVS / 2 + 2) * 5 + SYNC + 2;
        for (int i = 0; i <= bound; i++) begin
            @(negedge clk);
            rx_i = (i < 15) ? 1'b0 : 1'b1;
            if (rx_busy_o) saw = 1;
            else if (saw != 0 && fell < 0) fell = i;
        end
        chk("glitch_busy_seen", saw, 1);
        chk("glitch_busy_cleared", (fell >= 0) ? 1 : 0, 1);
        settle(1);
        chk("glitch_no_valid", n_valid - nv, 0);
        chk("glitch_no_break", n_break - nb0, 0);

        nv = n_valid; send(8'h5A, 8, 2'b00, 0, 0, 2'b00, 3, 0, 1); settle(1);
        check_frame("bit_glitch", nv, 8'h5A, 0, 0);

        // Line held low for 12 bit times
        nv = n_valid; nb0 = n_break;
        expq.push_back('{brk: 1'b1, d: 8'h00, pe: 1'b0, fe: 1'b0});
        data_bits_i = 8; parity_mode_i = 0; stop_bits_i = 0;
        for (int i = 0; i < 12 * OVS * 5; i++) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
        chk("break_busy_while_low", rx_busy_o, 1);
        idle(SYNC + 4);
        chk("break_busy_after_rise", rx_busy_o, 0);
        settle(1);
        chk("break_pulses", n_break - nb0, 1);
        chk("break_no_valid", n_valid - nv, 0);
        nv = n_valid; send(8'h55, 8, 2'b00, 0, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("after_break", nv, 8'h55, 0, 0);

        nv = n_valid;
        send(8'hFF, 8, 2'b00, 0, 0, 2'b00, -1, 1, 0); settle(1);
        send(8'h81, 8, 2'b00, 0, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("disable_abort", nv, 8'h81, 0, 0);

        nv = n_valid;
        send(8'hFF, 8, 2'b00, 0, 0, 2'b00, -1, 2, 0); settle(1);
        chk("post_reset_outputs", {rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o,
                                   rx_break_o, rx_busy_o}, 0);
        send(8'h81, 8, 2'b00, 0, 0, 2'b00, -1, 0, 1); settle(1);
        check_frame("reset_abort", nv, 8'h81, 0, 0);

        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            clk_div_i = $urandom_range(0, 3);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            send(d, $urandom_range(3, 10), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
                 -1, 0, 1);
            settle(1 + $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
